// File: rtl/lc3b_mem_responder.sv
// Word-organized memory responder for the LC-3b MEM-stage port (read, byte-lane write).
// Latency: mem_resp exactly LATENCY cycles after acceptance; one request per LATENCY+1 cycles.
// Backpressure: the initiator holds its request until mem_resp; inputs are ignored while busy.
module lc3b_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_byte_enable,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_resp,
    output logic        busy,
    output logic        err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // Counter only needs to hold LATENCY-2
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;
    // Address bits outside the word index: bit 0 and everything above log2(DEPTH_WORDS)
    localparam logic [15:0] ADDR_DROP = ~(16'((DEPTH_WORDS - 1) << 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           op_write;
    logic [AW-1:0]  idx;
    logic [1:0]     be_q;
    logic [15:0]    wdata_q;

    logic [15:0]    mem [DEPTH_WORDS];

    logic [AW-1:0]  req_idx;
    logic           unused_addr;

    // Word index drops bit 0 and wraps the byte address modulo DEPTH_WORDS*2
    assign req_idx     = mem_address[AW:1];
    assign unused_addr = ^(mem_address & ADDR_DROP);

    // Request sequencer: latch on acceptance, count out the latency, pulse mem_resp.
    // Read data is prefetched into mem_rdata on the edge entering RESP, so it is
    // stable for the whole response cycle and holds afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_resp  <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            mem_rdata <= 16'h0000;
            op_write  <= 1'b0;
            idx       <= '0;
            be_q      <= 2'b00;
            wdata_q   <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        // A simultaneous read+write is executed as a write and flagged
                        op_write <= mem_write;
                        idx      <= req_idx;
                        be_q     <= mem_byte_enable;
                        wdata_q  <= mem_wdata;
                        busy     <= 1'b1;
                        if (mem_read && mem_write) begin
                            err <= 1'b1;
                        end
                        if (LATENCY == 1) begin
                            state    <= RESP;
                            mem_resp <= 1'b1;
                            if (!mem_write) begin
                                mem_rdata <= mem[req_idx];
                            end
                        end else begin
                            cnt   <= CNT_LOAD;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state    <= RESP;
                        mem_resp <= 1'b1;
                        if (!op_write) begin
                            mem_rdata <= mem[idx];
                        end
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    mem_resp <= 1'b0;
                    busy     <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    mem_resp <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Byte-lane write commit at the end of RESP; suppressed when reset is asserted that cycle
    always_ff @(posedge clk) begin
        if (rst_n && (state == RESP) && op_write) begin
            if (be_q[0]) begin
                mem[idx][7:0] <= wdata_q[7:0];
            end
            if (be_q[1]) begin
                mem[idx][15:8] <= wdata_q[15:8];
            end
        end
    end

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Bench for lc3b_mem_responder: scoreboard + reference model on a LATENCY=3 instance,
// plus a LATENCY=1 instance exercised with back-to-back reads.
module tb_lc3b_mem_responder;

    localparam int L  = 3;
    localparam int D  = 256;
    localparam int L1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;

    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [1:0]  mem_byte_enable = 2'b00;
    logic [15:0] mem_address = 16'h0, mem_wdata = 16'h0;
    logic [15:0] mem_rdata;
    logic        mem_resp, busy, err;

    logic        s1_read = 1'b0, s1_write = 1'b0;
    logic [1:0]  s1_be = 2'b00;
    logic [15:0] s1_addr = 16'h0, s1_wdata = 16'h0;
    logic [15:0] s1_rdata;
    logic        s1_resp, s1_busy, s1_err;

    lc3b_mem_responder #(.DEPTH_WORDS(D), .LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp), .busy(busy), .err(err)
    );

    lc3b_mem_responder #(.DEPTH_WORDS(D), .LATENCY(L1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .mem_read(s1_read), .mem_write(s1_write),
        .mem_byte_enable(s1_be), .mem_address(s1_addr),
        .mem_wdata(s1_wdata), .mem_rdata(s1_rdata),
        .mem_resp(s1_resp), .busy(s1_busy), .err(s1_err)
    );

    typedef struct {
        bit          is_read;
        logic [15:0] data;
        int          acc;
    } exp_t;

    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    bit          rst_q      = 1'b1;
    bit          mon_en     = 1'b0;
    exp_t        sbq[$];
    logic [15:0] model [D];
    int          acc        = -1;
    int          err_cyc    = -1;
    logic [15:0] last_rd    = 16'h0;
    logic [15:0] seen_rd;
    logic [15:0] model1 [4];
    bit          prev1      = 1'b0;

    function automatic int widx(logic [15:0] a);
        return (int'(a) / 2) % D;
    endfunction

    function automatic logic [15:0] merge(logic [15:0] old, logic [1:0] be, logic [15:0] wd);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0]  = wd[7:0];
        if (be[1]) r[15:8] = wd[15:8];
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        rst_q  = rst_n;
        mon_en = 1'b1;
    end

    // Monitor for the LATENCY=3 instance
    always @(negedge clk) begin : mon
        exp_t e;
        bit   exp_resp, exp_busy, exp_err;
        if (mon_en) begin
            if (!rst_q) begin
                check("rst_resp", {31'b0, mem_resp}, 0);
                check("rst_busy", {31'b0, busy}, 0);
                check("rst_err", {31'b0, err}, 0);
                check("rst_rdata", {16'b0, mem_rdata}, 0);
                last_rd = 16'h0;
            end else begin
                exp_resp = (acc >= 0) && (cyc == acc + L);
                exp_busy = (acc >= 0) && (cyc > acc) && (cyc <= acc + L);
                exp_err  = (err_cyc >= 0) && (cyc > err_cyc);
                check("resp", {31'b0, mem_resp}, {31'b0, exp_resp});
                check("busy", {31'b0, busy}, {31'b0, exp_busy});
                check("err", {31'b0, err}, {31'b0, exp_err});
                if (mem_resp && sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("resp_latency", cyc, e.acc + L);
                    if (e.is_read) begin
                        check("rdata", {16'b0, mem_rdata}, {16'b0, e.data});
                        last_rd = e.data;
                    end else begin
                        check("rdata_hold_wr", {16'b0, mem_rdata}, {16'b0, last_rd});
                    end
                end else if (!mem_resp) begin
                    check("rdata_hold", {16'b0, mem_rdata}, {16'b0, last_rd});
                end
            end
        end
    end

    // LATENCY=1 instance: mem_resp must never be high two cycles in a row
    always @(negedge clk) begin
        if (mon_en && rst_q) begin
            if (s1_resp) check("l1_no_consecutive", {31'b0, prev1}, 0);
            prev1 = s1_resp;
        end
    end

    // Issue one request to the LATENCY=3 instance and hold it until mem_resp
    task automatic issue(bit rd, bit wr, logic [15:0] a, logic [1:0] be, logic [15:0] wd);
        exp_t e;
        bit   got;
        mem_read = rd; mem_write = wr; mem_address = a;
        mem_byte_enable = be; mem_wdata = wd;
        e.is_read = rd && !wr;
        e.data    = model[widx(a)];
        e.acc     = cyc;
        sbq.push_back(e);
        acc = cyc;
        if (rd && wr && err_cyc < 0) err_cyc = cyc;
        got = 1'b0;
        for (int k = 0; k < L + 4 && !got; k++) begin
            @(negedge clk);
            got = mem_resp;
            seen_rd = mem_rdata;
        end
        if (!got) begin
            compared++; mismatched++;
            $display("FAIL resp_timeout: got no mem_resp want one (addr %h)", a);
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        if (wr && got) model[widx(a)] = merge(model[widx(a)], be, wd);
    endtask

    task automatic s1_wait(output int rc, output bit got);
        got = 1'b0; rc = -1;
        for (int k = 0; k < L1 + 4 && !got; k++) begin
            @(negedge clk);
            got = s1_resp;
            rc  = cyc;
        end
        if (!got) begin
            compared++; mismatched++;
            $display("FAIL l1_timeout: got no mem_resp want one (cycle %0d)", cyc);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  r, gap, rc, sc, prev_rc;
        bit  got;
        logic [15:0] a, wd;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill every word so later reads have known contents
        for (int i = 0; i < D; i++) issue(0, 1, 16'(i * 2), 2'b11, 16'($urandom));

        // Basic write/read
        issue(0, 1, 16'h0010, 2'b11, 16'hBEEF);
        issue(1, 0, 16'h0010, 2'b00, 16'h0);
        check("basic_beef", {16'b0, seen_rd}, 32'hBEEF);

        // Byte lanes
        issue(0, 1, 16'h0020, 2'b11, 16'h1234);
        issue(0, 1, 16'h0020, 2'b10, 16'hAB00);
        issue(0, 1, 16'h0020, 2'b01, 16'h00CD);
        issue(0, 1, 16'h0020, 2'b00, 16'hFFFF);
        issue(1, 0, 16'h0020, 2'b11, 16'h0);
        check("byte_lanes", {16'b0, seen_rd}, 32'hABCD);

        // Address wrap and bit 0
        issue(0, 1, 16'h0201, 2'b11, 16'h5A5A);
        issue(1, 0, 16'h0000, 2'b00, 16'h0);
        check("wrap_rd0", {16'b0, seen_rd}, 32'h5A5A);
        issue(1, 0, 16'h0001, 2'b00, 16'h0);
        check("wrap_rd1", {16'b0, seen_rd}, 32'h5A5A);

        // Illegal read+write
        issue(1, 1, 16'h0040, 2'b11, 16'h0F0F);
        issue(1, 0, 16'h0040, 2'b00, 16'h0);
        check("illegal_data", {16'b0, seen_rd}, 32'h0F0F);
        check("illegal_err", {31'b0, err}, 1);

        // Random traffic with idle gaps
        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(0, 19);
            a  = 16'($urandom);
            wd = 16'($urandom);
            if (r == 0)      issue(1, 1, a, 2'($urandom), wd);
            else if (r < 10) issue(1, 0, a, 2'($urandom), wd);
            else             issue(0, 1, a, 2'($urandom), wd);
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
        end

        // Reset in the middle of a write
        issue(0, 1, 16'h0050, 2'b11, 16'h1111);
        mem_write = 1'b1; mem_address = 16'h0050; mem_byte_enable = 2'b11; mem_wdata = 16'h7777;
        sbq.push_back('{1'b0, model[widx(16'h0050)], cyc});
        acc = cyc;
        @(posedge clk); #1;
        rst_n = 1'b0;
        mem_write = 1'b0; mem_read = 1'b1; mem_address = 16'h0050;
        @(posedge clk); #1;
        sbq.delete(); acc = -1; err_cyc = -1;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        issue(1, 0, 16'h0050, 2'b00, 16'h0);
        check("reset_abort_data", {16'b0, seen_rd}, 32'h1111);
        check("reset_err_clear", {31'b0, err}, 0);

        // LATENCY=1 instance: fill four words, then back-to-back reads
        for (int i = 0; i < 4; i++) begin
            model1[i] = 16'($urandom);
            s1_write = 1'b1; s1_be = 2'b11; s1_addr = 16'(i * 2); s1_wdata = model1[i];
            s1_wait(rc, got);
            @(posedge clk); #1;
            s1_write = 1'b0;
        end
        prev_rc = -1;
        for (int i = 0; i < 8; i++) begin
            s1_read = 1'b1; s1_addr = 16'((i % 4) * 2);
            sc = cyc;
            s1_wait(rc, got);
            check("l1_latency", rc, sc + L1);
            check("l1_rdata", {16'b0, s1_rdata}, {16'b0, model1[i % 4]});
            if (prev_rc >= 0) check("l1_spacing", rc - prev_rc, 2);
            prev_rc = rc;
            @(posedge clk); #1;
        end
        s1_read = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("final_queue_empty", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lc3b_mem_responder.md
# lc3b_mem_responder

Memory responder for the LC-3b pipeline's MEM-stage interface. The pipeline raises `mem_read` or `mem_write` with `mem_byte_enable`, address and write data, then holds them until `mem_resp`. This block answers that request after a fixed, parameterized latency from a word-organized backing store. It is the bench and FPGA stand-in for physical memory and sits behind the data port of the pipeline datapath.

## Interface
Parameters:
- `DEPTH_WORDS`, default 256: number of 16-bit words; power of two, ≥2.
- `LATENCY`, default 3: cycles from request acceptance to `mem_resp`; ≥1.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `mem_read`  in  1  read request; held by the initiator until `mem_resp`.
- `mem_write`  in  1  write request; held by the initiator until `mem_resp`.
- `mem_byte_enable`  in  2  write byte lanes: bit0 = data[7:0], bit1 = data[15:8].
- `mem_address`  in  16  byte address; bit 0 is ignored.
- `mem_wdata`  in  16  write data.
- `mem_rdata`  out  16  read data; valid in the `mem_resp` cycle of a read.
- `mem_resp`  out  1  one-cycle completion pulse.
- `busy`  out  1  high while a request is latched (WAIT or RESP state).
- `err`  out  1  sticky flag; set when `mem_read` and `mem_write` are both high at acceptance.

## Operation
- **States:** IDLE, WAIT, RESP.
- **IDLE:**
  - With `mem_read | mem_write` high, latch the op, the word index, `mem_byte_enable` and `mem_wdata`.
  - If `LATENCY`=1, go to RESP. Otherwise load `cnt` = `LATENCY`-2 and go to WAIT.
  - With no request, stay in IDLE.
- **WAIT:** while `cnt`≠0, decrement `cnt`. When `cnt`=0, go to RESP.
- **RESP:**
  - Drive `mem_resp`=1.
  - Read: `mem_rdata` = stored word for the whole cycle, combinationally from the array or via a prefetch register.
  - Write: update only the enabled byte lanes at the end of this cycle.
  - Always go to IDLE next.
- **Word index:** `mem_address`[log2(`DEPTH_WORDS`):1]. Upper address bits are dropped, so addresses wrap modulo `DEPTH_WORDS`*2 bytes.
- **Byte enable on reads:** ignored. Reads always return the full word.
- **Write with `mem_byte_enable`=00:** no change to memory, but still completes with `mem_resp`.
- **Read and write both high at acceptance:** treated as a write, and `err` is set. `err` is cleared only by reset.
- **Inputs after acceptance:** ignored until return to IDLE. Dropping or changing the request mid-transaction does not abort it; the latched request completes and pulses `mem_resp`.
- **`mem_rdata` outside a read RESP cycle:** holds its last read value.
- **Storage:** contents are not cleared by reset and are X until written.

## Timing
- **Acceptance:** request high in IDLE during cycle c → `mem_resp` high in cycle c+`LATENCY` for exactly one cycle.
- **Back-to-back requests:** earliest next acceptance is cycle c+`LATENCY`+1, which gives a throughput of one request per `LATENCY`+1 cycles.
- **`busy`:** high from cycle c+1 through c+`LATENCY`.
- **Read-after-write:** a write committed at the end of its RESP cycle is visible to any later read.
- **Reset values** (one cycle after `rst_n` is sampled low): state=IDLE, `cnt`=0, `mem_resp`=0, `busy`=0, `err`=0, `mem_rdata`=16'h0000.
- **Reset mid-transaction:**
  - Reset in WAIT or RESP aborts the transaction. No `mem_resp` is issued afterwards.
  - A write whose RESP cycle coincides with `rst_n`=0 is not committed.
  - Outputs follow the reset values above.
- **Request held high across reset release:** accepted in the first cycle with `rst_n`=1.

## Test plan
- **Basic write/read, `LATENCY`=3:**
  - Stimulus: write 16'hBEEF to 0x0010 with be=11, then read 0x0010.
  - Required: each `mem_resp` arrives exactly 3 cycles after acceptance; read returns 16'hBEEF; `busy` high for 3 cycles per access.
- **Byte lanes:**
  - Stimulus: write 16'h1234 to 0x0020 (be=11), write 16'hAB00 (be=10), write 16'h00CD (be=01), write 16'hFFFF (be=00), then read 0x0020.
  - Required: read returns 16'hABCD; all four writes pulse `mem_resp`.
- **Address handling, `DEPTH_WORDS`=256:**
  - Stimulus: write 16'h5A5A to 0x0201, then read 0x0000 and 0x0001.
  - Required: both reads return 16'h5A5A (bit 0 ignored, wraps at 512 bytes).
- **Back-to-back reads with `LATENCY`=1:**
  - Stimulus: initiator drops each request on the `mem_resp` edge and raises the next one immediately.
  - Required: `mem_resp` pulses every 2 cycles and is never high in two consecutive cycles.
- **Illegal request:**
  - Stimulus: `mem_read`=`mem_write`=1 with data 16'h0F0F at 0x0040.
  - Required: `err`=1 and stays set; a subsequent read of 0x0040 returns 16'h0F0F; `err` returns to 0 only after `rst_n` low.
- **Reset mid-write:**
  - Stimulus: write 16'h7777 to 0x0050 (which holds 16'h1111), assert `rst_n`=0 in WAIT, release, then read 0x0050.
  - Required: no `mem_resp` is issued for the aborted write; the read returns 16'h1111; all outputs take their reset values during reset.
